// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoder definitions: instruction formats, major opcodes and
// the signed immediate ranges each format can represent.
package rv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;

    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] IMM13_MIN = -32'sd4096;
    localparam logic signed [31:0] IMM13_MAX = 32'sd4094;
    localparam logic signed [31:0] IMM21_MIN = -32'sd1048576;
    localparam logic signed [31:0] IMM21_MAX = 32'sd1048574;

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Scatters a signed byte immediate into its instruction-word bit positions
// for the given format and flags values the format cannot represent.
module imm_pack
    import rv_enc_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [31:0] imm_i,
    output logic [31:0] bits_o,
    output logic        err_o
);

    logic signed [31:0] imm_s;
    fmt_e               fmt;

    assign imm_s = $signed(imm_i);
    assign fmt   = fmt_e'(fmt_i);

    always_comb begin
        bits_o = '0;
        err_o  = 1'b0;
        case (fmt)
            FMT_R: ;
            FMT_I: begin
                bits_o[31:20] = imm_i[11:0];
                err_o         = !in_range(imm_s, IMM12_MIN, IMM12_MAX);
            end
            FMT_S: begin
                bits_o[31:25] = imm_i[11:5];
                bits_o[11:7]  = imm_i[4:0];
                err_o         = !in_range(imm_s, IMM12_MIN, IMM12_MAX);
            end
            FMT_B: begin
                bits_o[31]    = imm_i[12];
                bits_o[7]     = imm_i[11];
                bits_o[30:25] = imm_i[10:5];
                bits_o[11:8]  = imm_i[4:1];
                err_o         = imm_i[0] || !in_range(imm_s, IMM13_MIN, IMM13_MAX);
            end
            FMT_U: begin
                bits_o[31:12] = imm_i[31:12];
                err_o         = |imm_i[11:0];
            end
            FMT_J: begin
                bits_o[31]    = imm_i[20];
                bits_o[30:21] = imm_i[10:1];
                bits_o[20]    = imm_i[11];
                bits_o[19:12] = imm_i[19:12];
                err_o         = imm_i[0] || !in_range(imm_s, IMM21_MIN, IMM21_MAX);
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: one-deep output register behind a valid/ready
// handshake, emitting packed words with sequential instruction-memory addresses.
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              err_sticky,
    input  logic              clr_err,
    output logic [CNT_W-1:0]  word_cnt,
    input  logic              restart
);

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sticky_q, sticky_d;

    logic [31:0] imm_bits;
    logic        imm_err;
    logic [31:0] enc;
    logic        accept;
    logic        xfer;

    imm_pack u_imm_pack (
        .fmt_i  (fmt),
        .imm_i  (imm),
        .bits_o (imm_bits),
        .err_o  (imm_err)
    );

    always_comb begin
        enc = '0;
        case (fmt_e'(fmt))
            FMT_R:        enc = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:        enc = imm_bits | {12'b0, rs1, funct3, rd, opcode};
            FMT_S, FMT_B: enc = imm_bits | {7'b0, rs2, rs1, funct3, 5'b0, opcode};
            FMT_U, FMT_J: enc = imm_bits | {20'b0, rd, opcode};
            default:      enc = '0;
        endcase
    end

    // restart drops the held word, so it also blocks both accept and transfer
    assign in_ready = !restart && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = valid_q && out_ready && !restart;

    always_comb begin
        valid_d  = valid_q;
        instr_d  = instr_q;
        err_d    = err_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;

        if (xfer && err_q) begin
            sticky_d = 1'b1;
        end else if (clr_err) begin
            sticky_d = 1'b0;
        end

        if (restart) begin
            valid_d = 1'b0;
            addr_d  = BASE_ADDR;
            cnt_d   = '0;
        end else begin
            if (xfer) begin
                valid_d = 1'b0;
                addr_d  = addr_q + ADDR_W'(4);
                cnt_d   = cnt_q + CNT_W'(1);
            end
            if (accept) begin
                valid_d = 1'b1;
                instr_d = enc;
                err_d   = imm_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            instr_q  <= '0;
            err_q    <= 1'b0;
            addr_q   <= BASE_ADDR;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_instr  = instr_q;
    assign out_err    = err_q;
    assign out_addr   = addr_q;
    assign word_cnt   = cnt_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed field bundles with hand-encoded
// expected words; a monitor pops and checks each word as it transfers.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_addr;
    logic        out_err, err_sticky, clr_err, restart;
    logic [15:0] word_cnt;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_addr;
    logic [31:0] last_instr;
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .out_err    (out_err),
        .err_sticky (err_sticky),
        .clr_err    (clr_err),
        .word_cnt   (word_cnt),
        .restart    (restart)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dec_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] dec_j(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im);
        fmt = f; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im,
                        input logic [31:0] ei, input logic ee);
        int t = 0;
        @(negedge clk); #1;
        drive(f, op, f3, f7, d, s1, s2, im);
        in_valid = 1'b1;
        #1;
        while (!in_ready && t < 50) begin
            @(negedge clk); #2;
            t++;
        end
        if (!in_ready) begin
            n_vec++; n_miss++;
            $display("FAIL accept_timeout: in_ready stuck low, wanted 1");
        end else begin
            sb.push_back('{instr: ei, err: ee});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk); #4;
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++; n_miss++;
            $display("FAIL drain_timeout: %0d words pending, wanted 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    // Monitor: a word transfers at the posedge following this sample point.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #3;
            if (rst_n && !restart && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_word: got 0x%08h, wanted none", out_instr);
                end else begin
                    e = sb.pop_front();
                    chk("instr", out_instr, e.instr);
                    chk("err",   {31'b0, out_err}, {31'b0, e.err});
                    chk("addr",  out_addr, exp_addr);
                    exp_addr   = exp_addr + 32'd4;
                    last_instr = out_instr;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, wanted completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        clr_err = 1'b0; restart = 1'b0; exp_addr = BASE; last_instr = '0;
        drive(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err",   {31'b0, out_err}, 32'd0);
        chk("rst_sticky",    {31'b0, err_sticky}, 32'd0);
        chk("rst_word_cnt",  {16'b0, word_cnt}, 32'd0);
        chk("rst_out_addr",  out_addr, BASE);
        chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        @(negedge clk); #1 rst_n = 1'b1;

        // R, I, S
        send(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
        send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00293, 1'b0);
        send(3'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b0);
        drain();
        chk("word_cnt_ris", {16'b0, word_cnt}, 32'd3);

        // B, J with round trip through the decode concatenation
        send(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 32'hFE208CE3, 1'b0);
        drain();
        chk("b_roundtrip", dec_b(last_instr), 32'hFFFFFFF8);
        send(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h001000EF, 1'b0);
        drain();
        chk("j_roundtrip", dec_j(last_instr), 32'h00000800);

        // Errors and sticky flag
        send(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3, 32'h00000163, 1'b1);
        drain();
        chk("sticky_set", {31'b0, err_sticky}, 32'd1);
        @(negedge clk); #1 clr_err = 1'b1;
        @(negedge clk); #1 clr_err = 1'b0;
        chk("sticky_clr", {31'b0, err_sticky}, 32'd0);
        send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2048, 32'h80000013, 1'b1);
        @(negedge clk); #1 clr_err = 1'b1;
        @(negedge clk); #1 clr_err = 1'b0;
        chk("sticky_set_wins", {31'b0, err_sticky}, 32'd1);
        send(3'd7, 7'h7F, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        send(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
        drain();
        @(negedge clk); #1 clr_err = 1'b1;
        @(negedge clk); #1 clr_err = 1'b0;
        chk("sticky_clr2", {31'b0, err_sticky}, 32'd0);
        chk("word_cnt_9", {16'b0, word_cnt}, 32'd9);

        // Backpressure: hold out_ready low with the next bundle waiting
        @(negedge clk); #1 out_ready = 1'b0;
        send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0);
        @(negedge clk); #1;
        drive(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd6);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready",  {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_out_instr", out_instr, 32'h00500093);
            chk("bp_out_addr",  out_addr, BASE + 32'd36);
            @(negedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
        sb.push_back('{instr: 32'h00600113, err: 1'b0});
        @(posedge clk); #1 in_valid = 1'b0;
        send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd7, 32'h00700193, 1'b0);
        drain();
        chk("word_cnt_12", {16'b0, word_cnt}, 32'd12);

        // restart while a word is held
        @(negedge clk); #1 out_ready = 1'b0;
        send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd8, 32'h00800213, 1'b0);
        @(negedge clk); #1;
        restart = 1'b1; in_valid = 1'b1;
        #1;
        chk("restart_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        restart = 1'b0; in_valid = 1'b0;
        sb.delete();
        exp_addr = BASE;
        chk("restart_out_valid", {31'b0, out_valid}, 32'd0);
        chk("restart_out_addr",  out_addr, BASE);
        chk("restart_word_cnt",  {16'b0, word_cnt}, 32'd0);
        out_ready = 1'b1;
        send(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
        drain();
        chk("restart_word_cnt1", {16'b0, word_cnt}, 32'd1);

        // Asynchronous reset mid-stream with a word held and sticky set
        send(3'd6, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 32'h00000000, 1'b1);
        drain();
        chk("sticky_fmt6", {31'b0, err_sticky}, 32'd1);
        @(negedge clk); #1 out_ready = 1'b0;
        send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd9, 32'h00900293, 1'b0);
        @(negedge clk); #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_out_instr", out_instr, 32'd0);
        chk("arst_out_err",   {31'b0, out_err}, 32'd0);
        chk("arst_sticky",    {31'b0, err_sticky}, 32'd0);
        chk("arst_word_cnt",  {16'b0, word_cnt}, 32'd0);
        chk("arst_out_addr",  out_addr, BASE);
        sb.delete();
        exp_addr = BASE;
        @(negedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        send(3'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b0);
        drain();
        chk("post_rst_word_cnt", {16'b0, word_cnt}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Pipelined RISC-V RV32I instruction encoder: the inverse of the PPU immediate extraction and concatenation helpers.
- Accepts decoded fields (format, opcode, funct, registers, signed immediate) over a valid/ready handshake.
- Emits packed 32-bit instruction words plus a sequential instruction-memory write address.
- Used by the test/boot loader to fill instruction memory; its output round-trips through the PPU decode path.

Parameters:
- ADDR_W, 32, width of output address and base address.
- BASE_ADDR, 0, address of first emitted word.
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6..7 illegal.
- opcode  input  7  instr[6:0].
- funct3  input  3  instr[14:12] (R/I/S/B).
- funct7  input  7  instr[31:25] (R only).
- rd, rs1, rs2  input  5 each  register indices.
- imm  input  32  signed immediate/offset in bytes; U uses the full 32-bit value.
- out_valid  output  1  word valid.
- out_ready  input  1  consumer accepts word.
- out_instr  output  32  encoded word.
- out_addr  output  ADDR_W  memory address of out_instr.
- out_err  output  1  this word's fields were illegal.
- err_sticky  output  1  set by any out_err transfer; cleared by clr_err.
- clr_err  input  1  synchronous clear of err_sticky.
- word_cnt  output  CNT_W  number of completed output transfers; wraps modulo 2^CNT_W.
- restart  input  1  synchronous: drop held word, reset address to BASE_ADDR, zero word_cnt.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_instr=0, out_err=0, err_sticky=0, word_cnt=0, out_addr=BASE_ADDR.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
- Latency: one cycle. A bundle accepted at edge N appears on out_instr at N+1.
- Output hold: out_instr, out_addr and out_err stay stable while out_valid && !out_ready.
- Throughput: full rate when out_ready stays high (simultaneous transfer and accept in the same cycle).
- out_addr: increments by 4 after each output transfer; wraps modulo 2^ADDR_W.
- Encoding per format (common fields: opcode in [6:0], rd in [11:7], funct3 in [14:12], rs1 in [19:15], rs2 in [24:20] where the format uses them):
  - R: funct7 in [31:25].
  - I: imm[11:0] in [31:20].
  - S: imm[11:5] in [31:25], imm[4:0] in [11:7].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Legality (out_err=1 when violated):
  - I, S: imm in [-2048, 2047].
  - B: imm[0]=0 and imm in [-4096, 4094].
  - J: imm[0]=0 and imm in [-1048576, 1048574].
  - U: imm[11:0]=0.
  - R: imm ignored, never an error.
  - fmt 6/7: always an error, out_instr=0.
- On error the word is still emitted (with the truncated encoding) and the address still advances.
- err_sticky:
  - Set on an output transfer with out_err=1.
  - clr_err coincident with a setting transfer: set wins.
- restart:
  - Takes priority over everything except reset.
  - Next cycle: out_valid=0, out_addr=BASE_ADDR, word_cnt=0.
  - A bundle presented in the restart cycle is not accepted; in_ready is forced to 0 that cycle.
  - err_sticky is unaffected.
- Reset mid-transfer: the held word is discarded with no partial state retained.

Decomposition:
- Shared package rv_enc_pkg:
  - format enum (FMT_R..FMT_J).
  - opcode constants: OP_REG=0110011, OP_IMM=0010011, STORE=0100011, BRANCH=1100011, LUI=0110111, JAL=1101111.
  - immediate range limits.
- Sub-module imm_pack (combinational): fmt + imm -> {imm field bits, err}. The top level owns the handshake, output register, address/counter and sticky error.

Test Plan:
- R: fmt=0, opcode=0110011, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> out_instr=0x002081B3, out_addr=BASE_ADDR, out_err=0, one cycle after accept.
- I/S: addi x5,x0,-1 (imm=0xFFFFFFFF) -> 0xFFF00293; then sw x2,8(x1) -> 0x0020A423 at address +4; word_cnt=2.
- B/J: beq x1,x2,-8 -> 0xFE208CE3; jal x1,2048 -> 0x001000EF. Feeding both words through the PPU B/J concatenation helpers returns 0xFFFFFFF8 and 0x00000800.
- Errors: B imm=3 -> out_err=1, err_sticky=1; I imm=2048 -> out_err=1; fmt=7 -> out_instr=0, out_err=1; clr_err -> err_sticky=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid held -> in_ready=0 and output stable throughout; release -> back-to-back words at consecutive addresses with no loss or duplication.
- restart/reset: restart while a word is held -> out_valid=0, out_addr=BASE_ADDR, word_cnt=0; assert rst_n=0 mid-stream -> all outputs reach reset values immediately, asynchronously.
